// File: rtl/adxl355_seq_ctrl.sv
// adxl355_seq_ctrl: sits in front of spi_master. After enable it writes RANGE
// and POWER_CTL once, then burst-reads the nine XDATA3..ZDATA1 bytes on every
// sample tick and presents signed 20-bit X/Y/Z with a one-cycle strobe.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | cs high, waiting for enable
// S_WR_RANGE  | cs low, writing RANGE_VAL to 0x2C
// S_GAP_RANGE | cs high gap after the RANGE write
// S_WR_PWR    | cs low, writing 0x00 to POWER_CTL (0x2D)
// S_GAP_PWR   | cs high gap after the POWER_CTL write
// S_WAIT      | cs high, waiting for a sample tick or a pending tick
// S_RD_BURST  | cs low, reading 9 bytes starting at 0x08
// S_GAP_RD    | cs high gap after a burst (completed or aborted)
module adxl355_seq_ctrl #(
  parameter int         BIT_CLKS   = 40,
  parameter int         CS_GAP     = 80,
  parameter int         SAMPLE_DIV = 25000,
  parameter int         RD_TIMEOUT = 4000,
  parameter logic [7:0] RANGE_VAL  = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        spi_cs_n,
  output logic        spi_wr_rd,
  output logic [6:0]  spi_addr,
  output logic [7:0]  spi_wdata,
  input  logic        spi_rd_vld,
  input  logic [7:0]  spi_rd_data,
  output logic [19:0] x_data,
  output logic [19:0] y_data,
  output logic [19:0] z_data,
  output logic        sample_vld,
  output logic        init_done,
  output logic        busy,
  output logic        err_timeout,
  output logic        sample_overrun
);

  localparam int TMR_W  = 16;
  localparam int TICK_W = $clog2(SAMPLE_DIV);

  localparam logic [TMR_W-1:0]  WR_LOAD   = TMR_W'(16 * BIT_CLKS - 1);
  localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'(CS_GAP - 1);
  localparam logic [TMR_W-1:0]  RD_LOAD   = TMR_W'(RD_TIMEOUT - 1);
  localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(SAMPLE_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_RANGE, S_GAP_RANGE, S_WR_PWR,
    S_GAP_PWR, S_WAIT, S_RD_BURST, S_GAP_RD
  } state_t;

  state_t state, state_nxt;

  logic [TMR_W-1:0]  timer, tmr_load;
  logic              tmr_zero;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              pending;
  logic [3:0]        byte_cnt;
  logic              last_byte;
  logic [19:0]       x_buf, y_buf;
  logic [15:0]       z_buf;

  assign tmr_zero  = (timer == '0);
  assign tick      = init_done && (tick_cnt == '0);
  assign last_byte = (state == S_RD_BURST) && spi_rd_vld && (byte_cnt == 4'd8);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; enable is only looked at where a gap or wait ends
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (enable) state_nxt = S_WR_RANGE;
      S_WR_RANGE:  if (tmr_zero) state_nxt = S_GAP_RANGE;
      S_GAP_RANGE: if (tmr_zero) state_nxt = enable ? S_WR_PWR : S_IDLE;
      S_WR_PWR:    if (tmr_zero) state_nxt = S_GAP_PWR;
      S_GAP_PWR:   if (tmr_zero) state_nxt = enable ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!enable)             state_nxt = S_IDLE;
        else if (tick || pending) state_nxt = S_RD_BURST;
      end
      S_RD_BURST:  if (last_byte || tmr_zero) state_nxt = S_GAP_RD;
      S_GAP_RD:    if (tmr_zero) state_nxt = enable ? S_WAIT : S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // SPI master inputs decoded from the state so they hold for all of cs low
  always_comb begin
    spi_cs_n  = 1'b1;
    spi_wr_rd = 1'b0;
    spi_addr  = 7'h00;
    spi_wdata = 8'h00;
    busy      = 1'b0;
    case (state)
      S_WR_RANGE: begin
        spi_cs_n  = 1'b0;
        spi_addr  = 7'h2C;
        spi_wdata = RANGE_VAL;
        busy      = 1'b1;
      end
      S_WR_PWR: begin
        spi_cs_n  = 1'b0;
        spi_addr  = 7'h2D;
        busy      = 1'b1;
      end
      S_RD_BURST: begin
        spi_cs_n  = 1'b0;
        spi_wr_rd = 1'b1;
        spi_addr  = 7'h08;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Per-state dwell time loaded when a state is entered
  always_comb begin
    tmr_load = '0;
    case (state_nxt)
      S_WR_RANGE, S_WR_PWR:            tmr_load = WR_LOAD;
      S_GAP_RANGE, S_GAP_PWR, S_GAP_RD: tmr_load = GAP_LOAD;
      S_RD_BURST:                      tmr_load = RD_LOAD;
      default:                         tmr_load = '0;
    endcase
  end

  // State dwell down-counter
  always_ff @(posedge clk) begin
    if (!rst_n)                  timer <= '0;
    else if (state_nxt != state) timer <= tmr_load;
    else if (!tmr_zero)          timer <= timer - 1'b1;
  end

  // Sample-rate down-counter, runs only once the sensor is configured
  always_ff @(posedge clk) begin
    if (!rst_n)                tick_cnt <= TICK_LOAD;
    else if (!init_done)       tick_cnt <= TICK_LOAD;
    else if (tick_cnt == '0)   tick_cnt <= TICK_LOAD;
    else                       tick_cnt <= tick_cnt - 1'b1;
  end

  // One-deep pending tick; a tick that finds it already set is an overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending        <= 1'b0;
      sample_overrun <= 1'b0;
    end else begin
      sample_overrun <= tick && pending;
      if (state_nxt == S_IDLE)
        pending <= 1'b0;
      else if (state == S_WAIT && state_nxt == S_RD_BURST)
        pending <= 1'b0;
      else if (tick)
        pending <= 1'b1;
    end
  end

  // init_done: set leaving the POWER_CTL write, cleared on the way back to idle
  always_ff @(posedge clk) begin
    if (!rst_n)                          init_done <= 1'b0;
    else if (state_nxt == S_IDLE)        init_done <= 1'b0;
    else if (state == S_WR_PWR && tmr_zero) init_done <= 1'b1;
  end

  // Byte capture and sample assembly; outputs move only on a complete burst
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt    <= '0;
      x_buf       <= '0;
      y_buf       <= '0;
      z_buf       <= '0;
      x_data      <= '0;
      y_data      <= '0;
      z_data      <= '0;
      sample_vld  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      sample_vld  <= 1'b0;
      err_timeout <= (state == S_RD_BURST) && tmr_zero && !last_byte;
      if (state != S_RD_BURST) begin
        byte_cnt <= '0;
      end else if (spi_rd_vld) begin
        byte_cnt <= byte_cnt + 4'd1;
        case (byte_cnt)
          4'd0: x_buf[19:12] <= spi_rd_data;
          4'd1: x_buf[11:4]  <= spi_rd_data;
          4'd2: x_buf[3:0]   <= spi_rd_data[7:4];
          4'd3: y_buf[19:12] <= spi_rd_data;
          4'd4: y_buf[11:4]  <= spi_rd_data;
          4'd5: y_buf[3:0]   <= spi_rd_data[7:4];
          4'd6: z_buf[15:8]  <= spi_rd_data;
          4'd7: z_buf[7:0]   <= spi_rd_data;
          default: begin
            x_data     <= x_buf;
            y_data     <= y_buf;
            z_data     <= {z_buf, spi_rd_data[7:4]};
            sample_vld <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adxl355_seq_ctrl.sv
// Bench for adxl355_seq_ctrl. dut drives the init/read/timeout/reset/disable
// sequence with a scoreboard of expected SPI transactions and samples; dut2
// runs with a very short sample period against a free-running slave to show
// back-to-back bursts and overrun pulses.
module tb_adxl355_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, spi_cs_n, spi_wr_rd, spi_rd_vld;
  logic [6:0]  spi_addr;
  logic [7:0]  spi_wdata, spi_rd_data;
  logic [19:0] x_data, y_data, z_data;
  logic        sample_vld, init_done, busy, err_timeout, sample_overrun;

  logic        rst2_n, enable2, spi_cs_n2, spi_wr_rd2, spi_rd_vld2;
  logic [6:0]  spi_addr2;
  logic [7:0]  spi_wdata2, spi_rd_data2;
  logic [19:0] x_data2, y_data2, z_data2;
  logic        sample_vld2, init_done2, busy2, err_timeout2, sample_overrun2;

  adxl355_seq_ctrl #(.SAMPLE_DIV(3000)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .spi_cs_n(spi_cs_n), .spi_wr_rd(spi_wr_rd), .spi_addr(spi_addr),
    .spi_wdata(spi_wdata), .spi_rd_vld(spi_rd_vld), .spi_rd_data(spi_rd_data),
    .x_data(x_data), .y_data(y_data), .z_data(z_data),
    .sample_vld(sample_vld), .init_done(init_done), .busy(busy),
    .err_timeout(err_timeout), .sample_overrun(sample_overrun)
  );

  adxl355_seq_ctrl #(.SAMPLE_DIV(100)) dut2 (
    .clk(clk), .rst_n(rst2_n), .enable(enable2),
    .spi_cs_n(spi_cs_n2), .spi_wr_rd(spi_wr_rd2), .spi_addr(spi_addr2),
    .spi_wdata(spi_wdata2), .spi_rd_vld(spi_rd_vld2), .spi_rd_data(spi_rd_data2),
    .x_data(x_data2), .y_data(y_data2), .z_data(z_data2),
    .sample_vld(sample_vld2), .init_done(init_done2), .busy(busy2),
    .err_timeout(err_timeout2), .sample_overrun(sample_overrun2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       wr_rd;
    logic [6:0] addr;
    logic [7:0] wdata;
    int         len;   // cs-low cycles, 0 = not checked
    int         gap;   // preceding cs-high cycles, 0 = not checked
    logic       vld;   // sample_vld at cs rise
    logic       err;   // err_timeout at cs rise
    logic       init;  // init_done at cs rise
  } txn_t;

  typedef struct {
    logic [19:0] x, y, z;
  } smp_t;

  txn_t exp_txn[$];
  smp_t exp_smp[$];
  int   ovr1 = 0;

  localparam logic [71:0] PAT_A = 72'h7F_FF_F0_80_00_00_00_00_10;
  localparam logic [71:0] PAT_P = 72'h55_66_77_88_99_00_00_00_00;
  localparam logic [71:0] PAT_B = 72'h12_34_56_AB_CD_EF_FE_DC_BA;
  localparam logic [71:0] PAT_C = 72'h00_01_2F_FF_FF_FF_80_00_0F;

  // Transaction and sample monitor for dut
  initial begin
    logic       prev_cs = 1'b1;
    int         low_cnt = 0, high_cnt = 0, gap_seen = 0;
    logic       cap_wr = 1'b0, unstable = 1'b0;
    logic [6:0] cap_addr = '0;
    logic [7:0] cap_wdata = '0;
    txn_t       t;
    smp_t       s;
    forever begin
      @(negedge clk);
      if (sample_overrun === 1'b1) ovr1++;
      if (sample_vld === 1'b1) begin
        if (exp_smp.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL smp_unexpected: sample_vld with empty queue, x=0x%0h", x_data);
        end else begin
          s = exp_smp.pop_front();
          check("smp_x", x_data, s.x);
          check("smp_y", y_data, s.y);
          check("smp_z", z_data, s.z);
        end
      end
      if (prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
        cap_wr = spi_wr_rd; cap_addr = spi_addr; cap_wdata = spi_wdata;
        low_cnt = 1; gap_seen = high_cnt; unstable = 1'b0;
      end else if (prev_cs === 1'b0 && spi_cs_n === 1'b0) begin
        low_cnt++;
        if (spi_wr_rd !== cap_wr || spi_addr !== cap_addr || spi_wdata !== cap_wdata)
          unstable = 1'b1;
      end else if (prev_cs === 1'b0 && spi_cs_n === 1'b1) begin
        if (exp_txn.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL txn_unexpected: cs pulse of %0d cycles addr 0x%0h with empty queue",
                   low_cnt, cap_addr);
        end else begin
          t = exp_txn.pop_front();
          check("txn_wr_rd", cap_wr, t.wr_rd);
          check("txn_addr", cap_addr, t.addr);
          check("txn_wdata", cap_wdata, t.wdata);
          check("txn_stable", unstable, 1'b0);
          if (t.len != 0) check("txn_len", low_cnt, t.len);
          if (t.gap != 0) check("txn_gap", gap_seen, t.gap);
          check("txn_sample_vld", sample_vld, t.vld);
          check("txn_err_timeout", err_timeout, t.err);
          check("txn_init_done", init_done, t.init);
        end
        high_cnt = 1;
      end else begin
        high_cnt++;
      end
      prev_cs = spi_cs_n;
    end
  end

  // Slave for dut: wait for a read cs, then return n bytes 21 cycles apart
  task automatic slave_burst(input logic [71:0] bytes, input int n, input int drop_at);
    int w = 0;
    while (!(spi_cs_n === 1'b0 && spi_wr_rd === 1'b1) && w < 8000) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (w >= 8000) begin
      n_fail++;
      $display("FAIL slave_wait: no read cs within %0d cycles", w);
      return;
    end
    for (int i = 0; i < n; i++) begin
      repeat (20) @(posedge clk);
      #1;
      if (i == drop_at) enable = 1'b0;
      spi_rd_vld  = 1'b1;
      spi_rd_data = bytes[71 - 8*i -: 8];
      @(posedge clk);
      #1 spi_rd_vld = 1'b0;
    end
  endtask

  task automatic wait_cs_high(input string name);
    int w = 0;
    while (spi_cs_n !== 1'b1 && w < 6000) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (w >= 6000) begin
      n_fail++;
      $display("FAIL %s: cs still low after %0d cycles", name, w);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, spi_cs_n, 1'b1);
    check({tag, "_wr_rd"}, spi_wr_rd, 1'b0);
    check({tag, "_addr"}, spi_addr, 7'h00);
    check({tag, "_wdata"}, spi_wdata, 8'h00);
    check({tag, "_x"}, x_data, 20'h0);
    check({tag, "_y"}, y_data, 20'h0);
    check({tag, "_z"}, z_data, 20'h0);
    check({tag, "_sample_vld"}, sample_vld, 1'b0);
    check({tag, "_init_done"}, init_done, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, err_timeout, 1'b0);
    check({tag, "_overrun"}, sample_overrun, 1'b0);
  endtask

  // dut2: free-running slave and monitor
  int nsmp2 = 0, ovr2 = 0, err2 = 0, nfall2 = 0;

  initial begin
    rst2_n = 1'b0; enable2 = 1'b0; spi_rd_vld2 = 1'b0; spi_rd_data2 = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst2_n = 1'b1; enable2 = 1'b1;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (spi_cs_n2 === 1'b0 && spi_wr_rd2 === 1'b1) begin
        for (int i = 0; i < 9; i++) begin
          repeat (50) @(posedge clk);
          #1 spi_rd_vld2 = 1'b1;
          spi_rd_data2 = PAT_B[71 - 8*i -: 8];
          @(posedge clk);
          #1 spi_rd_vld2 = 1'b0;
        end
        while (spi_cs_n2 !== 1'b1) @(negedge clk);
      end
    end
  end

  initial begin
    logic prev_cs2 = 1'b1;
    int   hi2 = 0;
    forever begin
      @(negedge clk);
      if (sample_overrun2 === 1'b1) ovr2++;
      if (err_timeout2 === 1'b1) err2++;
      if (sample_vld2 === 1'b1) begin
        nsmp2++;
        check("dut2_x", x_data2, 20'h12345);
        check("dut2_y", y_data2, 20'hABCDE);
        check("dut2_z", z_data2, 20'hFEDCB);
      end
      if (prev_cs2 === 1'b1 && spi_cs_n2 === 1'b0) begin
        if (spi_wr_rd2 === 1'b1) begin
          if (nfall2 >= 1) check("dut2_back_to_back_gap", hi2, 81);
          nfall2++;
        end
      end else if (spi_cs_n2 === 1'b1) begin
        hi2 = (prev_cs2 === 1'b0) ? 1 : hi2 + 1;
      end
      prev_cs2 = spi_cs_n2;
    end
  end

  // Main directed sequence for dut
  initial begin
    int w;
    rst_n = 1'b0; enable = 1'b0; spi_rd_vld = 1'b0; spi_rd_data = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // init writes and first sample
    exp_txn.push_back('{1'b0, 7'h2C, 8'h01, 640, 0,  1'b0, 1'b0, 1'b0});
    exp_txn.push_back('{1'b0, 7'h2D, 8'h00, 640, 80, 1'b0, 1'b0, 1'b1});
    exp_txn.push_back('{1'b1, 7'h08, 8'h00, 0,   0,  1'b1, 1'b0, 1'b1});
    exp_smp.push_back('{20'h7FFFF, 20'h80000, 20'h00001});
    enable = 1'b1;
    slave_burst(PAT_A, 9, -1);
    wait_cs_high("burst_a_end");
    repeat (3) @(negedge clk);
    check("init_done_after_init", init_done, 1'b1);

    // timeout burst keeps previous sample, then pending tick starts next burst
    exp_txn.push_back('{1'b1, 7'h08, 8'h00, 4000, 0, 1'b0, 1'b1, 1'b1});
    slave_burst(PAT_P, 5, -1);
    wait_cs_high("timeout_end");
    @(negedge clk);
    check("timeout_x_kept", x_data, 20'h7FFFF);
    check("timeout_y_kept", y_data, 20'h80000);
    check("timeout_z_kept", z_data, 20'h00001);
    exp_txn.push_back('{1'b1, 7'h08, 8'h00, 0, 81, 1'b1, 1'b0, 1'b1});
    exp_smp.push_back('{20'h12345, 20'hABCDE, 20'hFEDCB});
    slave_burst(PAT_B, 9, -1);
    wait_cs_high("burst_b_end");
    check("dut_no_overrun", ovr1, 0);

    // reset in the middle of a read burst
    w = 0;
    while (!(spi_cs_n === 1'b0 && spi_wr_rd === 1'b1) && w < 4000) begin
      @(negedge clk);
      w++;
    end
    check("reset_burst_started", (w < 4000), 1'b1);
    repeat (50) @(posedge clk);
    exp_txn.push_back('{1'b1, 7'h08, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0});
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_cs_next_edge", spi_cs_n, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_txn.push_back('{1'b0, 7'h2C, 8'h01, 640, 0,  1'b0, 1'b0, 1'b0});
    exp_txn.push_back('{1'b0, 7'h2D, 8'h00, 640, 80, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1 rst_n = 1'b1;

    // enable dropped mid-burst: burst completes, gap, then idle
    exp_txn.push_back('{1'b1, 7'h08, 8'h00, 0, 0, 1'b1, 1'b0, 1'b1});
    exp_smp.push_back('{20'h00012, 20'hFFFFF, 20'h80000});
    slave_burst(PAT_C, 9, 4);
    wait_cs_high("burst_c_end");
    repeat (85) @(negedge clk);
    check("disable_init_done", init_done, 1'b0);
    check("disable_cs_n", spi_cs_n, 1'b1);
    check("disable_busy", busy, 1'b0);
    check("disable_x", x_data, 20'h00012);
    repeat (4000) @(negedge clk);

    // dut2 results
    w = 0;
    while (nsmp2 < 3 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check("dut2_samples", (nsmp2 >= 3), 1'b1);
    check("dut2_overruns", (ovr2 >= 4), 1'b1);
    check("dut2_no_timeout", err2, 0);

    check("txn_queue_empty", exp_txn.size(), 0);
    check("smp_queue_empty", exp_smp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
